instruction_encoder: RTL and testbench

- Reverse of the control decoder: takes field-level instruction requests and packs them into 32-bit MIPS instruction words.
- Requests come from the debug injector or the boot sequencer.
- Rejects illegal opcode/format combinations.
- Buffers accepted words in a FIFO and presents each with its instruction-memory byte address to the imem write port, using a valid/ready handshake.

---
 rtl/instruction_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instruction_encoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs field-level instruction requests into 32-bit MIPS words and queues them with byte addresses.
// Optional: define INSTRUCTION_ENCODER_DELAY_SLOT_NOP_EN to append a NOP after every control-transfer word.
module instruction_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_format,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  addr_load,
    input  logic [ADDR_WIDTH-1:0] addr_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_word,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [ERR_WIDTH-1:0]  illegal_count,
    output logic                  busy
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + ADDR_WIDTH;
`ifdef INSTRUCTION_ENCODER_DELAY_SLOT_NOP_EN
    localparam int NEED_FREE = 2;
`else
    localparam int NEED_FREE = 1;
`endif

    logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
    logic [CNT_W-1:0]      count_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ERR_WIDTH-1:0]  illegal_count_reg;
    logic                  out_valid_reg;
    logic [31:0]           out_word_reg;
    logic [ADDR_WIDTH-1:0] out_address_reg;

    logic                  accept;
    logic                  deq;
    logic                  legal;
    logic                  is_ctrl;
    logic [31:0]           word_enc;
    logic                  push0;
    logic                  push1;
    logic [ENTRY_W-1:0]    wr_data0;
    logic [ENTRY_W-1:0]    wr_data1;
    logic [PTR_W-1:0]      wr_ptr_plus1;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      remain;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [ENTRY_W-1:0]    head_next;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [FIFO_DEPTH-1:0] wr_en0;
    logic [FIFO_DEPTH-1:0] wr_en1;
    logic                  addr_unused;

    assign addr_unused = ^addr_value[1:0];

    assign in_ready = !addr_load && (count_reg <= CNT_W'(FIFO_DEPTH - NEED_FREE));
    assign accept   = in_valid && in_ready;
    assign deq      = out_valid_reg && out_ready;

    always_comb begin
        legal    = 1'b0;
        word_enc = 32'h0;
        case (in_format)
            2'd0: begin
                legal    = (in_opcode == 6'h00);
                word_enc = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
            end
            2'd1: begin
                legal    = !(in_opcode == 6'h00 || in_opcode == 6'h02 || in_opcode == 6'h03);
                word_enc = {in_opcode, in_rs, in_rt, in_imm};
            end
            2'd2: begin
                legal    = (in_opcode == 6'h02 || in_opcode == 6'h03);
                word_enc = {in_opcode, in_target};
            end
            default: begin
                legal    = 1'b0;
                word_enc = 32'h0;
            end
        endcase
    end

`ifdef INSTRUCTION_ENCODER_DELAY_SLOT_NOP_EN
    always_comb begin
        is_ctrl = 1'b0;
        case (in_format)
            2'd0:    is_ctrl = (in_funct == 6'h08 || in_funct == 6'h09);
            2'd1:    is_ctrl = (in_opcode == 6'h01) || (in_opcode >= 6'h04 && in_opcode <= 6'h07);
            2'd2:    is_ctrl = 1'b1;
            default: is_ctrl = 1'b0;
        endcase
    end
`else
    assign is_ctrl = 1'b0;
`endif

    assign push0     = accept && legal;
    assign push1     = push0 && is_ctrl;
    assign wr_data0  = {word_enc, addr_reg};
    assign wr_data1  = {32'h0, addr_reg + ADDR_WIDTH'(4)};
    assign addr_step = push1 ? ADDR_WIDTH'(8) : ADDR_WIDTH'(4);

    assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);
    assign count_next   = count_reg + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(deq);
    assign remain       = count_reg - CNT_W'(deq);
    assign rd_ptr_next  = rd_ptr_reg + PTR_W'(deq);
    assign wr_ptr_next  = wr_ptr_reg + PTR_W'(push0) + PTR_W'(push1);

    // When nothing older survives the dequeue, the new head is the word being written now.
    always_comb begin
        if (count_next == '0) begin
            head_next = '0;
        end else if (remain == '0) begin
            head_next = wr_data0;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
            assign wr_en0[gi] = push0 && (wr_ptr_reg == PTR_W'(gi));
            assign wr_en1[gi] = push1 && (wr_ptr_plus1 == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en0[i]) begin
                mem[i] <= wr_data0;
            end else if (wr_en1[i]) begin
                mem[i] <= wr_data1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg         <= '0;
            rd_ptr_reg        <= '0;
            wr_ptr_reg        <= '0;
            addr_reg          <= '0;
            illegal_count_reg <= '0;
            out_valid_reg     <= 1'b0;
            out_word_reg      <= 32'h0;
            out_address_reg   <= '0;
        end else begin
            count_reg                       <= count_next;
            rd_ptr_reg                      <= rd_ptr_next;
            wr_ptr_reg                      <= wr_ptr_next;
            out_valid_reg                   <= (count_next != '0);
            {out_word_reg, out_address_reg} <= head_next;
            if (addr_load) begin
                addr_reg <= {addr_value[ADDR_WIDTH-1:2], 2'b00};
            end else if (push0) begin
                addr_reg <= addr_reg + addr_step;
            end
            if (accept && !legal && illegal_count_reg != '1) begin
                illegal_count_reg <= illegal_count_reg + ERR_WIDTH'(1);
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_word      = out_word_reg;
    assign out_address   = out_address_reg;
    assign illegal_count = illegal_count_reg;
    assign busy          = (count_reg != '0);
endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instruction_encoder;
    localparam int DEPTH = 4;
`ifdef INSTRUCTION_ENCODER_DELAY_SLOT_NOP_EN
    localparam int NEED = 2;
    localparam bit DSLOT = 1'b1;
`else
    localparam int NEED = 1;
    localparam bit DSLOT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_format;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        addr_load;
    logic [15:0] addr_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [15:0] out_address;
    logic [7:0]  illegal_count;
    logic        busy;

    instruction_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(16), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .addr_load(addr_load), .addr_value(addr_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_address(out_address),
        .illegal_count(illegal_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] q_word[$];
    logic [15:0] q_addr[$];
    logic [15:0] m_addr = 16'h0;
    int          m_ill  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_encode(input int fmt, input int op, input int rs, input int rt,
                                         input int rd, input int sh, input int fn, input int imm,
                                         input int tgt, output bit legal, output bit ctrl,
                                         output logic [31:0] w);
        longint v;
        legal = 0;
        ctrl  = 0;
        v     = 0;
        if (fmt == 0) begin
            legal = (op == 0);
            ctrl  = (fn == 8 || fn == 9);
            v = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11)
              + longint'(sh) * 64 + fn;
        end else if (fmt == 1) begin
            legal = !(op == 0 || op == 2 || op == 3);
            ctrl  = (op == 1 || (op >= 4 && op <= 7));
            v = longint'(op) * (1 << 26) + longint'(rs) * (1 << 21) + longint'(rt) * 65536 + imm;
        end else if (fmt == 2) begin
            legal = (op == 2 || op == 3);
            ctrl  = 1;
            v = longint'(op) * (1 << 26) + tgt;
        end
        w = v[31:0];
    endfunction

    function automatic bit model_ready();
        return !addr_load && ((DEPTH - q_word.size()) >= NEED);
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit exp_ready, acc, legal, ctrl;
        logic [31:0] w;
        #1;
        exp_ready = model_ready();
        if (!rst) begin
            check_val("in_ready", in_ready, exp_ready);
            check_val("out_valid", out_valid, q_word.size() != 0);
            check_val("busy", busy, q_word.size() != 0);
            check_val("illegal_count", illegal_count, m_ill);
            if (q_word.size() != 0) begin
                check_val("out_word", out_word, q_word[0]);
                check_val("out_address", out_address, q_addr[0]);
            end
        end
        if (rst) begin
            q_word.delete();
            q_addr.delete();
            m_addr = 16'h0;
            m_ill  = 0;
        end else begin
            acc = in_valid && exp_ready;
            if (q_word.size() != 0 && out_ready) begin
                $display("word %08h @%04h", q_word[0], q_addr[0]);
                void'(q_word.pop_front());
                void'(q_addr.pop_front());
            end
            if (addr_load) begin
                m_addr = addr_value & 16'hFFFC;
            end else if (acc) begin
                model_encode(in_format, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct,
                             in_imm, in_target, legal, ctrl, w);
                if (legal) begin
                    q_word.push_back(w);
                    q_addr.push_back(m_addr);
                    m_addr = m_addr + 16'd4;
                    if (DSLOT && ctrl) begin
                        q_word.push_back(32'h0);
                        q_addr.push_back(m_addr);
                        m_addr = m_addr + 16'd4;
                    end
                end else if (m_ill < 255) begin
                    m_ill++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic req(input int fmt, input int op, input int rs, input int rt, input int rd,
                       input int sh, input int fn, input int imm, input int tgt);
        in_valid  = 1'b1;
        in_format = 2'(fmt);
        in_opcode = 6'(op);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_shamt  = 5'(sh);
        in_funct  = 6'(fn);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        addr_load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] w, input logic [15:0] a);
        check_val({tag, "_valid"}, out_valid, 1'b1);
        check_val({tag, "_word"}, out_word, w);
        check_val({tag, "_addr"}, out_address, a);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_value = 16'h0; out_ready = 1'b0;
        in_format = 2'd0; in_opcode = 6'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_shamt = 5'd0; in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0;
        @(negedge clk);
        do_reset();
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_word", out_word, 32'h0);
        check_val("rst_out_address", out_address, 16'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);

        // Single R-type ADD
        out_ready = 1'b1;
        req(0, 0, 1, 2, 3, 0, 8'h20, 0, 0);
        expect_head("r_add", 32'h00221820, 16'h0000);

        // ADDIU then J with the sink stalled
        do_reset();
        out_ready = 1'b0;
        req(1, 8'h09, 0, 8, 0, 0, 0, 16'h1234, 0);
        req(2, 8'h02, 0, 0, 0, 0, 0, 0, 26'h0000100);
        check_val("stall_busy", busy, 1'b1);
        expect_head("addiu", 32'h24081234, 16'h0000);
        expect_head("jump", 32'h08000100, 16'h0004);
        if (DSLOT) expect_head("jump_nop", 32'h0, 16'h0008);

        // Illegal format/opcode combinations
        do_reset();
        out_ready = 1'b1;
        req(0, 8'h08, 1, 2, 3, 0, 8'h20, 0, 0);
        req(1, 8'h02, 1, 2, 0, 0, 0, 16'h5555, 0);
        req(3, 8'h09, 1, 2, 0, 0, 0, 16'h5555, 0);
        check_val("ill_cnt3", illegal_count, 8'd3);
        check_val("ill_nothing", out_valid, 1'b0);
        for (int i = 0; i < 300; i++) req(3, $urandom_range(0, 63), 0, 0, 0, 0, 0, 0, 0);
        check_val("ill_sat", illegal_count, 8'hFF);
        req(1, 8'h09, 0, 1, 0, 0, 0, 16'h0001, 0);
        check_val("ill_addr_unchanged", out_address, 16'h0000);

        // Fill to full, then drain one with a request pending: no pass-through
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b0;
            #1;
            if (model_ready()) req(1, 8'h09, 0, i, 0, 0, 0, i, 0);
        end
        in_valid = 1'b1; in_format = 2'd1; in_opcode = 6'h09; out_ready = 1'b1;
        #1;
        check_val("full_in_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_val("after_drain_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // Address load and wrap
        do_reset();
        out_ready = 1'b1;
        addr_load = 1'b1; addr_value = 16'hFFFB; in_valid = 1'b1;
        #1;
        check_val("load_in_ready", in_ready, 1'b0);
        tick();
        addr_load = 1'b0;
        req(1, 8'h09, 0, 1, 0, 0, 0, 16'h0001, 0);
        check_val("wrap_a0", out_address, 16'hFFF8);
        req(1, 8'h09, 0, 2, 0, 0, 0, 16'h0002, 0);
        check_val("wrap_a1", out_address, 16'hFFFC);
        req(1, 8'h09, 0, 3, 0, 0, 0, 16'h0003, 0);
        check_val("wrap_a2", out_address, 16'h0000);
        tick();

        // Branch with optional delay-slot NOP
        do_reset();
        out_ready = 1'b0;
        addr_load = 1'b1; addr_value = 16'h0010;
        tick();
        addr_load = 1'b0;
        req(1, 8'h04, 1, 2, 0, 0, 0, 16'hFFFF, 0);
        req(1, 8'h09, 0, 4, 0, 0, 0, 16'h0007, 0);
        expect_head("beq", 32'h1022FFFF, 16'h0010);
        if (DSLOT) begin
            expect_head("beq_nop", 32'h0, 16'h0014);
            expect_head("beq_next", 32'h24040007, 16'h0018);
        end else begin
            expect_head("beq_next", 32'h24040007, 16'h0014);
        end

        // Randomized traffic against the model, with occasional reset mid-transfer
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int op;
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            addr_load = ($urandom_range(0, 29) == 0);
            addr_value = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_format = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: op = 0;
                1: op = 1;
                2: op = 2;
                3: op = 3;
                4: op = $urandom_range(4, 7);
                5: op = 9;
                6: op = 8'h23;
                default: op = $urandom_range(0, 63);
            endcase
            in_opcode = 6'(op);
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_funct  = ($urandom_range(0, 3) == 0) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check_val("final_empty", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
